// File: rtl/pwm_thresh_cmp.sv
// PWM-programmed threshold comparator: two PWM inputs set the VIL/VIH thresholds by duty capture,
// and NCH sampled channels are compared against them with optional hysteresis.

module pwm_thresh_cap #(
  parameter int             W       = 8,
  parameter int             PRE     = 2,
  parameter int             TIMEOUT = 4096,
  parameter logic [W-1:0]   DEF     = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm,
  output logic [W-1:0] thr,
  output logic         upd,
  output logic         stale
);

  localparam int              CW        = W + PRE;
  localparam int              TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic          rise, fall, timeout;
  logic [CW-1:0] cnt;
  logic [TW-1:0] idle_cnt;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  // An edge always clears idle_cnt, so a timeout can never coincide with a capture.
  assign timeout = (state != IDLE) && !rise && !fall && (idle_cnt == IDLE_LAST);

  // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      idle_cnt <= '0;
      thr      <= DEF;
      upd      <= 1'b0;
      stale    <= 1'b1;
    end else begin
      s1  <= pwm;
      s2  <= s1;
      s3  <= s2;
      upd <= 1'b0;

      if (rise || fall)       idle_cnt <= '0;
      else if (state != IDLE) idle_cnt <= idle_cnt + 1'b1;

      if (timeout) begin
        thr      <= DEF;
        stale    <= 1'b1;
        state    <= IDLE;
        cnt      <= '0;
        idle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
          end
          HIGH: begin
            if (fall) begin
              thr   <= cnt[CW-1:PRE];
              upd   <= 1'b1;
              stale <= 1'b0;
              state <= LOW;
            end else if (s2 && cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

module pwm_thresh_cmp #(
  parameter int           NCH     = 5,
  parameter int           W       = 8,
  parameter int           PRE     = 2,
  parameter logic [W-1:0] VIL_DEF = 8'h55,
  parameter logic [W-1:0] VIH_DEF = 8'hAA,
  parameter int           HYST    = 0,
  parameter int           TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VIL_PWM,
  input  logic             VIH_PWM,
  input  logic             smpl_vld,
  input  logic [NCH*W-1:0] smpl_data,
  output logic [NCH-1:0]   chL,
  output logic [NCH-1:0]   chH,
  output logic             out_vld,
  output logic [W-1:0]     VIL,
  output logic [W-1:0]     VIH,
  output logic [1:0]       thr_upd,
  output logic [1:0]       stale,
  output logic             thr_err
);

  localparam logic        [W:0] HYST_U = (W+1)'(HYST);
  localparam logic signed [W:0] HYST_S = $signed((W+1)'(HYST));

  logic        [W:0]     lo_lim;
  logic signed [W:0]     hi_lim;
  logic        [NCH-1:0] chl_nxt, chh_nxt;

  pwm_thresh_cap #(.W(W), .PRE(PRE), .TIMEOUT(TIMEOUT), .DEF(VIL_DEF)) u_vil (
    .clk(clk), .rst(rst), .pwm(VIL_PWM), .thr(VIL), .upd(thr_upd[0]), .stale(stale[0])
  );

  pwm_thresh_cap #(.W(W), .PRE(PRE), .TIMEOUT(TIMEOUT), .DEF(VIH_DEF)) u_vih (
    .clk(clk), .rst(rst), .pwm(VIH_PWM), .thr(VIH), .upd(thr_upd[1]), .stale(stale[1])
  );

  assign thr_err = (VIL >= VIH);

  // Release limits are one bit wider than the data so VIL+HYST cannot wrap and VIH-HYST cannot underflow.
  assign lo_lim = {1'b0, VIL} + HYST_U;
  assign hi_lim = $signed({1'b0, VIH}) - HYST_S;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] d;
    assign d          = smpl_data[i*W +: W];
    assign chl_nxt[i] = chL[i] ? ({1'b0, d} < lo_lim)          : (d < VIL);
    assign chh_nxt[i] = chH[i] ? ($signed({1'b0, d}) > hi_lim) : (d > VIH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chL     <= '0;
      chH     <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= smpl_vld;
      if (smpl_vld) begin
        chL <= chl_nxt;
        chH <= chh_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_thresh_cmp.sv
// Self-checking bench for pwm_thresh_cmp: one plain instance and one with HYST=4 sharing all inputs.

module tb_pwm_thresh_cmp;

  localparam int NCH = 5;
  localparam int W   = 8;
  localparam int HY  = 4;

  logic             clk = 1'b0;
  logic             rst, vil_pwm, vih_pwm, smpl_vld;
  logic [NCH*W-1:0] smpl_data;

  logic [NCH-1:0] ch_l, ch_h, hch_l, hch_h;
  logic           out_vld, hout_vld, thr_err, hthr_err;
  logic [W-1:0]   vil, vih, hvil, hvih;
  logic [1:0]     thr_upd, stale, hthr_upd, hstale;

  pwm_thresh_cmp dut (
    .clk(clk), .rst(rst), .VIL_PWM(vil_pwm), .VIH_PWM(vih_pwm),
    .smpl_vld(smpl_vld), .smpl_data(smpl_data),
    .chL(ch_l), .chH(ch_h), .out_vld(out_vld), .VIL(vil), .VIH(vih),
    .thr_upd(thr_upd), .stale(stale), .thr_err(thr_err)
  );

  pwm_thresh_cmp #(.HYST(HY)) dut_h (
    .clk(clk), .rst(rst), .VIL_PWM(vil_pwm), .VIH_PWM(vih_pwm),
    .smpl_vld(smpl_vld), .smpl_data(smpl_data),
    .chL(hch_l), .chH(hch_h), .out_vld(hout_vld), .VIL(hvil), .VIH(hvih),
    .thr_upd(hthr_upd), .stale(hstale), .thr_err(hthr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       el, eh;   // plain instance
    logic       hl, hh;   // hysteresis instance
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pwm(input bit sel, input logic v);
    if (sel) vih_pwm = v;
    else     vil_pwm = v;
  endtask

  task automatic fill_channels(input logic [7:0] d0, input logic [7:0] rest);
    smpl_data[W-1:0] = d0;
    for (int i = 1; i < NCH; i++) smpl_data[i*W +: W] = rest;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      smpl_vld = 1'b1;
      fill_channels(vecs[k].d, 8'h80);
      tick();
      check($sformatf("vec%0d_chl", k),  ch_l[0],  vecs[k].el);
      check($sformatf("vec%0d_chh", k),  ch_h[0],  vecs[k].eh);
      check($sformatf("vec%0d_hchl", k), hch_l[0], vecs[k].hl);
      check($sformatf("vec%0d_hchh", k), hch_h[0], vecs[k].hh);
      check($sformatf("vec%0d_vld", k),  out_vld,  1'b1);
    end
  endtask

  // One PWM period: high for `high` sampled clocks, then low for the remainder.
  // Threshold = floor(high / 4); capture appears on the 3rd clock of the low phase.
  task automatic pwm_period(input bit sel, input int high, input int period, input logic [7:0] exp_thr);
    int ups = 0;
    int upd_at = -1;
    drive_pwm(sel, 1'b1);
    repeat (high) begin
      tick();
      if (thr_upd[sel]) ups++;
    end
    drive_pwm(sel, 1'b0);
    for (int t = 1; t <= period - high; t++) begin
      tick();
      if (thr_upd[sel]) begin
        ups++;
        if (upd_at < 0) upd_at = t;
      end
    end
    check($sformatf("pwm%0d_upd_count", sel), ups, 1);
    check($sformatf("pwm%0d_upd_latency", sel), upd_at, 3);
    check($sformatf("pwm%0d_thr", sel), sel ? vih : vil, exp_thr);
    check($sformatf("pwm%0d_thr_h", sel), sel ? hvih : hvil, exp_thr);
    check($sformatf("pwm%0d_stale", sel), stale[sel], 1'b0);
  endtask

  function automatic logic [7:0] pick(input int thr);
    int v;
    if ($urandom_range(0, 2) == 0) v = thr - 6 + int'($urandom_range(0, 12));
    else                           v = int'($urandom_range(0, 255));
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ml[NCH], mh[NCH], hl[NCH], hh[NCH];
    int vil_m, vih_m;
    logic [NCH-1:0] el, eh, ehl, ehh;
    int rev, ups;

    // plain: d<0x55 / d>0xAA; hysteresis: release at >=0x59 / <=0xA6
    for (int k = 0; k < 10; k++) begin
      vecs[k] = (k % 2 == 0) ? '{8'h30, 1'b1, 1'b0, 1'b1, 1'b0}
                             : '{8'hC0, 1'b0, 1'b1, 1'b0, 1'b1};
    end
    vecs[10] = '{8'h54, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'hAB, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'hA6, 1'b0, 1'b0, 1'b0, 1'b0};
    // VIL = 0x40 ramp: hysteresis releases at >= 0x44
    vecs[16] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{8'h3F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{8'h42, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{8'h43, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{8'h44, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; vil_pwm = 1'b0; vih_pwm = 1'b0; smpl_vld = 1'b0; smpl_data = '0;
    #1;
    check("rst_vil", vil, 8'h55);
    check("rst_vih", vih, 8'hAA);
    check("rst_stale", stale, 2'b11);
    check("rst_chl", ch_l, '0);
    check("rst_chh", ch_h, '0);
    check("rst_vld", out_vld, 1'b0);
    check("rst_upd", thr_upd, 2'b00);
    check("rst_err", thr_err, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Default thresholds, fixed vectors, then hold when smpl_vld drops.
    apply_vecs(0, 15);
    smpl_vld = 1'b0;
    fill_channels(8'h10, 8'h10);
    tick();
    check("novld_out_vld", out_vld, 1'b0);
    check("novld_hold_chl", ch_l[0], 1'b0);
    check("stale_idle", stale, 2'b11);

    // Random samples against a reference model; every channel is at 0/0 after the table.
    vil_m = 8'h55; vih_m = 8'hAA;
    for (int i = 0; i < NCH; i++) begin ml[i] = 0; mh[i] = 0; hl[i] = 0; hh[i] = 0; end
    for (int n = 0; n < 300; n++) begin
      logic [7:0] d;
      int dv;
      smpl_vld = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) begin
        d = pick(($urandom_range(0, 1) == 0) ? vil_m : vih_m);
        smpl_data[i*W +: W] = d;
        dv = int'(d);
        if (smpl_vld) begin
          ml[i] = (dv < vil_m) ? 1 : 0;
          mh[i] = (dv > vih_m) ? 1 : 0;
          if (hl[i] != 0) hl[i] = (dv >= vil_m + HY) ? 0 : 1;
          else            hl[i] = (dv < vil_m) ? 1 : 0;
          if (hh[i] != 0) hh[i] = (dv <= vih_m - HY) ? 0 : 1;
          else            hh[i] = (dv > vih_m) ? 1 : 0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        el[i] = (ml[i] != 0); eh[i] = (mh[i] != 0);
        ehl[i] = (hl[i] != 0); ehh[i] = (hh[i] != 0);
      end
      tick();
      check("rand_chl", ch_l, el);
      check("rand_chh", ch_h, eh);
      check("rand_hchl", hch_l, ehl);
      check("rand_hchh", hch_h, ehh);
      check("rand_vld", out_vld, smpl_vld);
      check("rand_hvld", hout_vld, smpl_vld);
    end
    smpl_vld = 1'b0;

    // PWM capture: 400/1024 -> 0x64, 800/1024 -> 0xC8.
    pwm_period(1'b0, 400, 1024, 8'h64);
    pwm_period(1'b0, 400, 1024, 8'h64);
    pwm_period(1'b1, 800, 1024, 8'hC8);
    pwm_period(1'b1, 800, 1024, 8'hC8);
    check("err_after_caps", thr_err, 1'b0);

    // Stuck high: rise is acted on at the 3rd clock, revert 4096 clocks later.
    vil_pwm = 1'b1;
    rev = -1; ups = 0;
    for (int t = 1; t <= 5000; t++) begin
      tick();
      if (rev < 0 && vil == 8'h55) rev = t;
      if (thr_upd[0]) ups++;
    end
    check("stuck_hi_revert_at", rev, 4099);
    check("stuck_hi_stale", stale[0], 1'b1);
    vil_pwm = 1'b0;
    repeat (20) begin
      tick();
      if (thr_upd[0]) ups++;
    end
    check("stuck_hi_no_upd", ups, 0);
    check("stuck_hi_vil", vil, 8'h55);

    // Stuck low after a capture: fall acted on at low clock 3, revert 4096 clocks later.
    vil_pwm = 1'b1;
    repeat (400) tick();
    vil_pwm = 1'b0;
    rev = -1;
    for (int t = 1; t <= 5000; t++) begin
      tick();
      if (t > 3 && rev < 0 && vil == 8'h55) rev = t;
    end
    check("stuck_lo_revert_at", rev, 4099);
    check("stuck_lo_stale", stale[0], 1'b1);
    check("vih_timed_out", vih, 8'hAA);
    check("vih_stale", stale[1], 1'b1);

    // Hysteresis ramp with VIL = 0x40.
    vil_pwm = 1'b1;
    repeat (256) tick();
    vil_pwm = 1'b0;
    repeat (10) tick();
    check("vil_40", vil, 8'h40);
    apply_vecs(16, 21);

    // VIL above VIH: ordering error, both flags set on 0xB0.
    smpl_vld = 1'b0;
    vil_pwm = 1'b1;
    repeat (832) tick();
    vil_pwm = 1'b0;
    repeat (10) tick();
    check("vil_d0", vil, 8'hD0);
    check("stale_10", stale, 2'b10);
    check("thr_err", thr_err, 1'b1);
    check("thr_err_h", hthr_err, 1'b1);
    smpl_vld = 1'b1;
    fill_channels(8'hB0, 8'h80);
    tick();
    check("err_chl", ch_l[0], 1'b1);
    check("err_chh", ch_h[0], 1'b1);
    check("err_hchl", hch_l[0], 1'b1);
    check("err_hchh", hch_h[0], 1'b1);

    // Capture coincident with a sample: old VIL (0xD0) applies, new (0x64) from the next one.
    smpl_vld = 1'b0;
    vil_pwm = 1'b1;
    repeat (400) tick();
    vil_pwm = 1'b0;
    repeat (2) tick();
    smpl_vld = 1'b1;
    fill_channels(8'h80, 8'h80);
    tick();
    check("coinc_upd", thr_upd[0], 1'b1);
    check("coinc_vil", vil, 8'h64);
    check("coinc_chl_old", ch_l[0], 1'b1);
    check("coinc_hchl_old", hch_l[0], 1'b1);
    tick();
    check("coinc_chl_new", ch_l[0], 1'b0);
    check("coinc_hchl_new", hch_l[0], 1'b0);

    // Async reset mid-HIGH with live outputs; partial pulse must be discarded.
    fill_channels(8'h10, 8'h10);
    vil_pwm = 1'b1;
    repeat (100) tick();
    check("pre_rst_chl", ch_l[0], 1'b1);
    #2;
    rst = 1'b1;
    smpl_vld = 1'b0;
    #1;
    check("arst_vil", vil, 8'h55);
    check("arst_vih", vih, 8'hAA);
    check("arst_stale", stale, 2'b11);
    check("arst_chl", ch_l, '0);
    check("arst_hchl", hch_l, '0);
    check("arst_vld", out_vld, 1'b0);
    check("arst_upd", thr_upd, 2'b00);
    repeat (5) tick();
    vil_pwm = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    ups = 0;
    repeat (30) begin
      tick();
      if (thr_upd[0]) ups++;
    end
    check("arst_no_upd", ups, 0);
    check("arst_vil_kept", vil, 8'h55);
    check("arst_stale_kept", stale[0], 1'b1);
    pwm_period(1'b0, 400, 1024, 8'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
